pc_trace_sampler: RTL and testbench

//  Synthesizable PC sampler for the HSM SoC simulation harness; sits directly downstream of the CPU

---
 rtl/pc_trace_sampler.sv | 145 ++++++++++++++
 tb/tb_pc_trace_sampler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_sampler.sv
// Periodic {cycle, pc} sampler with a first-word-fall-through FIFO drain port,
// a saturating drop counter and a stalled-core flag.
module pc_trace_sampler #(
  parameter int unsigned PERIOD      = 100000,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic [CNT_WIDTH-1:0] cycle,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] out_cycle,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [15:0]          dropped,
  output logic                 stalled
);

  localparam int unsigned PHW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SW  = $clog2(STALL_LIMIT + 1);
  localparam int unsigned EW  = CNT_WIDTH + PC_WIDTH;

  localparam logic [PHW-1:0] PH_LAST  = PHW'(PERIOD - 1);
  localparam logic [SW-1:0]  ST_MAX   = SW'(STALL_LIMIT);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    ONE_CNT  = (AW + 1)'(1);

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [PHW-1:0]       phase_q, phase_d;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        rd_next;
  logic [AW:0]          count_q, count_d;
  logic [EW-1:0]        head_q, head_d;
  logic [15:0]          dropped_q, dropped_d;
  logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
  logic [SW-1:0]        stall_q, stall_d;
  logic                 stalled_q, stalled_d;

  logic          sample;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          drop;
  logic [EW-1:0] sample_w;

  always_comb begin
    sample    = en && (phase_q == '0);
    pop       = (count_q != '0) && out_ready;
    full      = (count_q == FULL_CNT);
    do_push   = sample && (!full || pop);
    drop      = sample && full && !pop;
    sample_w  = {cycle_q, pc};
    rd_next   = rd_ptr_q + 1'b1;

    cycle_d   = cycle_q;
    phase_d   = phase_q;
    last_pc_d = last_pc_q;
    stall_d   = stall_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    dropped_d = dropped_q;

    if (en) begin
      cycle_d   = cycle_q + 1'b1;
      phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      last_pc_d = pc;
      if (pc == last_pc_q) begin
        stall_d = (stall_q == ST_MAX) ? stall_q : stall_q + 1'b1;
      end else begin
        stall_d = '0;
      end
    end

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_next;

    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Head is a separate register so it can hold its last value once the FIFO empties.
    if (pop) begin
      if (count_q > ONE_CNT) begin
        head_d = mem_q[rd_next];
      end else if (do_push) begin
        head_d = sample_w;
      end
    end else if ((count_q == '0) && do_push) begin
      head_d = sample_w;
    end

    if (drop && (dropped_q != '1)) dropped_d = dropped_q + 1'b1;

    stalled_d = (stall_d == ST_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      phase_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      dropped_q <= '0;
      last_pc_q <= '0;
      stall_q   <= '0;
      stalled_q <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      phase_q   <= phase_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      dropped_q <= dropped_d;
      last_pc_q <= last_pc_d;
      stall_q   <= stall_d;
      stalled_q <= stalled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= sample_w;
  end

  assign cycle     = cycle_q;
  assign out_valid = (count_q != '0);
  assign out_cycle = head_q[EW-1 -: CNT_WIDTH];
  assign out_pc    = head_q[PC_WIDTH-1:0];
  assign dropped   = dropped_q;
  assign stalled   = stalled_q;

endmodule

// File: tb/tb_pc_trace_sampler.sv
// Directed bench for pc_trace_sampler (PERIOD=4, DEPTH=4, STALL_LIMIT=3, CNT_WIDTH=8).
module tb_pc_trace_sampler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] pc;
  logic [7:0]  cycle;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_cycle;
  logic [31:0] out_pc;
  logic [15:0] dropped;
  logic        stalled;

  int total = 0;
  int bad   = 0;

  pc_trace_sampler #(
    .PERIOD(4),
    .CNT_WIDTH(8),
    .PC_WIDTH(32),
    .DEPTH(4),
    .STALL_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .pc(pc),
    .cycle(cycle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cycle(out_cycle),
    .out_pc(out_pc),
    .dropped(dropped),
    .stalled(stalled)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] pc;
    logic        rdy;
    logic [7:0]  e_cycle;
    logic        e_valid;
    logic [7:0]  e_ocycle;
    logic [31:0] e_opc;
    logic [15:0] e_drop;
    logic        e_stall;
  } vec_t;

  vec_t tab1 [11];
  vec_t tab2 [5];

  function automatic vec_t mk(logic r, logic e, logic [31:0] p, logic rd, logic [7:0] ec,
                              logic ev, logic [7:0] eoc, logic [31:0] eop, logic [15:0] ed,
                              logic es);
    vec_t v;
    v.rst = r; v.en = e; v.pc = p; v.rdy = rd;
    v.e_cycle = ec; v.e_valid = ev; v.e_ocycle = eoc; v.e_opc = eop;
    v.e_drop = ed; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input string tag, input int idx, input vec_t v);
    string n;
    rst = v.rst; en = v.en; pc = v.pc; out_ready = v.rdy;
    step();
    n = $sformatf("%s[%0d]", tag, idx);
    chk({n, ".cycle"},     cycle,     v.e_cycle);
    chk({n, ".out_valid"}, out_valid, v.e_valid);
    chk({n, ".out_cycle"}, out_cycle, v.e_ocycle);
    chk({n, ".out_pc"},    out_pc,    v.e_opc);
    chk({n, ".dropped"},   dropped,   v.e_drop);
    chk({n, ".stalled"},   stalled,   v.e_stall);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pc = '0; out_ready = 1'b0;

    // Reset, then periodic capture with a ready consumer.
    //              rst en  pc         rdy cyc valid ocyc opc        drop stall
    tab1[0]  = mk(1'b1, 1'b0, 32'h000, 1'b0, 8'd0,  1'b0, 8'd0, 32'h000, 16'd0, 1'b0);
    tab1[1]  = mk(1'b0, 1'b1, 32'h100, 1'b1, 8'd1,  1'b1, 8'd0, 32'h100, 16'd0, 1'b0);
    tab1[2]  = mk(1'b0, 1'b1, 32'h104, 1'b1, 8'd2,  1'b0, 8'd0, 32'h100, 16'd0, 1'b0);
    tab1[3]  = mk(1'b0, 1'b1, 32'h108, 1'b1, 8'd3,  1'b0, 8'd0, 32'h100, 16'd0, 1'b0);
    tab1[4]  = mk(1'b0, 1'b1, 32'h10C, 1'b1, 8'd4,  1'b0, 8'd0, 32'h100, 16'd0, 1'b0);
    tab1[5]  = mk(1'b0, 1'b1, 32'h110, 1'b1, 8'd5,  1'b1, 8'd4, 32'h110, 16'd0, 1'b0);
    tab1[6]  = mk(1'b0, 1'b1, 32'h114, 1'b1, 8'd6,  1'b0, 8'd4, 32'h110, 16'd0, 1'b0);
    tab1[7]  = mk(1'b0, 1'b1, 32'h118, 1'b1, 8'd7,  1'b0, 8'd4, 32'h110, 16'd0, 1'b0);
    tab1[8]  = mk(1'b0, 1'b1, 32'h11C, 1'b1, 8'd8,  1'b0, 8'd4, 32'h110, 16'd0, 1'b0);
    tab1[9]  = mk(1'b0, 1'b1, 32'h120, 1'b1, 8'd9,  1'b1, 8'd8, 32'h120, 16'd0, 1'b0);
    tab1[10] = mk(1'b0, 1'b1, 32'h124, 1'b1, 8'd10, 1'b0, 8'd8, 32'h120, 16'd0, 1'b0);

    // Full FIFO: pop+push on sample cycle 24, then drain with en=0.
    tab2[0] = mk(1'b0, 1'b1, 32'h160, 1'b1, 8'd25, 1'b1, 8'd4,  32'h110, 16'd2, 1'b0);
    tab2[1] = mk(1'b0, 1'b0, 32'h160, 1'b1, 8'd25, 1'b1, 8'd8,  32'h120, 16'd2, 1'b0);
    tab2[2] = mk(1'b0, 1'b0, 32'h160, 1'b1, 8'd25, 1'b1, 8'd12, 32'h130, 16'd2, 1'b0);
    tab2[3] = mk(1'b0, 1'b0, 32'h160, 1'b1, 8'd25, 1'b1, 8'd24, 32'h160, 16'd2, 1'b0);
    tab2[4] = mk(1'b0, 1'b0, 32'h160, 1'b1, 8'd25, 1'b0, 8'd24, 32'h160, 16'd2, 1'b0);

    for (int i = 0; i < 11; i++) apply_vec("basic", i, tab1[i]);

    // Overflow: no consumer for 24 enabled cycles.
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      pc = 32'h100 + 32'(4 * c);
      step();
      if (c == 19) chk("ovf_drop_mid", dropped, 32'd1);
    end
    chk("ovf.cycle",     cycle,     32'd24);
    chk("ovf.out_valid", out_valid, 32'd1);
    chk("ovf.out_cycle", out_cycle, 32'd0);
    chk("ovf.out_pc",    out_pc,    32'h100);
    chk("ovf.dropped",   dropped,   32'd2);

    for (int i = 0; i < 5; i++) apply_vec("fullpp", i, tab2[i]);

    // Reset with three entries queued and a ready consumer.
    en = 1'b1; out_ready = 1'b0; pc = 32'h400;
    for (int c = 0; c < 12; c++) step();
    chk("rstq.pre_cycle",   cycle,     32'd37);
    chk("rstq.pre_valid",   out_valid, 32'd1);
    chk("rstq.pre_ocycle",  out_cycle, 32'd28);
    chk("rstq.pre_dropped", dropped,   32'd2);
    rst = 1'b1; out_ready = 1'b1; pc = 32'h500;
    step();
    chk("rstq.valid",   out_valid, 32'd0);
    chk("rstq.dropped", dropped,   32'd0);
    chk("rstq.cycle",   cycle,     32'd0);
    chk("rstq.ocycle",  out_cycle, 32'd0);
    chk("rstq.opc",     out_pc,    32'd0);
    rst = 1'b0;
    step();
    chk("rstq.first_valid", out_valid, 32'd1);
    chk("rstq.first_cycle", out_cycle, 32'd0);
    chk("rstq.first_pc",    out_pc,    32'h500);
    chk("rstq.cycle1",      cycle,     32'd1);

    // Stall detection and freeze under en=0.
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; out_ready = 1'b1; pc = 32'h200;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall.rise[%0d]", k), stalled, (k >= 3) ? 32'd1 : 32'd0);
    end
    en = 1'b0; pc = 32'h204;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("stall.frz[%0d]", k), stalled, 32'd1);
      chk($sformatf("stall.frzcyc[%0d]", k), cycle, 32'd5);
    end
    en = 1'b1;
    step();
    chk("stall.fall",  stalled, 32'd0);
    chk("stall.cycle", cycle,   32'd6);

    // Cycle counter wrap at 8 bits.
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 252; n++) begin
      pc = 32'h1000 + 32'(n);
      step();
    end
    chk("wrap.cyc252", cycle,     32'd252);
    chk("wrap.empty",  out_valid, 32'd0);
    out_ready = 1'b0;
    for (int n = 252; n < 261; n++) begin
      pc = 32'h1000 + 32'(n);
      step();
      if (n == 255) chk("wrap.to0", cycle, 32'd0);
    end
    chk("wrap.cycle5", cycle,     32'd5);
    chk("wrap.h0c",    out_cycle, 32'd252);
    chk("wrap.h0p",    out_pc,    32'h10FC);
    en = 1'b0; out_ready = 1'b1;
    step();
    chk("wrap.h1c", out_cycle, 32'd0);
    chk("wrap.h1p", out_pc,    32'h1100);
    step();
    chk("wrap.h2c", out_cycle, 32'd4);
    chk("wrap.h2p", out_pc,    32'h1104);
    step();
    chk("wrap.drained", out_valid, 32'd0);
    chk("wrap.dropped", dropped,   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
